// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand side (in_*) and result side (out_*, res, flags, err).
// master drives operands and out_ready; slave is the pipeline itself.
`timescale 1ns/1ps
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [3:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, a, b, shamt, funct, out_ready,
    input  in_ready, out_valid, res, flags, err
  );

  modport slave (
    input  in_valid, a, b, shamt, funct, out_ready,
    output in_ready, out_valid, res, flags, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 registers operands, stage 2 computes and holds the result.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for funct 9.
`timescale 1ns/1ps
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_NOT = 4'd5;
  localparam logic [3:0] F_SLA = 4'd6;
  localparam logic [3:0] F_SRA = 4'd7;
  localparam logic [3:0] F_SRL = 4'd8;

  // Stage 1: captured operand bundle
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [SHW-1:0]   s1_sh_q, s1_sh_d;
  logic [3:0]       s1_f_q, s1_f_d;

  // Stage 2: result register presented downstream
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic             s1_adv;
  logic             in_rdy;

  // Combinational ALU on the stage-1 bundle
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_illegal;
  logic [3:0]       alu_flags;

  always_comb begin
    amt         = (s1_sh_q != '0) ? s1_sh_q : s1_b_q[SHW-1:0];
    add_w       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    // Top bit of the widened difference is the unsigned borrow.
    sub_w       = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (s1_f_q)
      F_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
        alu_ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (add_w[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      F_SUB: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = sub_w[WIDTH];
        alu_ovf   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (sub_w[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      F_AND:   alu_res = s1_a_q & s1_b_q;
      F_OR:    alu_res = s1_a_q | s1_b_q;
      F_XOR:   alu_res = s1_a_q ^ s1_b_q;
      F_NOT:   alu_res = ~s1_a_q;
      F_SLA:   alu_res = s1_a_q << amt;
      F_SRA:   alu_res = $signed(s1_a_q) >>> amt;
      F_SRL:   alu_res = s1_a_q >> amt;
      default: alu_illegal = 1'b1;
    endcase
    // Illegal ops report all-zero flags, including zero.
    if (alu_illegal) begin
      alu_flags = 4'b0000;
    end else begin
      alu_flags = {alu_ovf, alu_carry, alu_res[WIDTH-1], (alu_res == '0)};
    end
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] F_MUL = 4'd9;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_t;

  mul_state_t         mul_st_q, mul_st_d;
  logic [SHW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0]   mul_mcand_q, mul_mcand_d;
  logic [2*WIDTH-1:0] mul_prod_q, mul_prod_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic               mul_take;

  // Product register {hi, lo}: lo starts as the multiplier and shifts out one bit per step.
  always_comb begin
    mul_sum  = {1'b0, mul_prod_q[2*WIDTH-1:WIDTH]} +
               (mul_prod_q[0] ? {1'b0, mul_mcand_q} : '0);
    mul_step = {mul_sum, mul_prod_q[WIDTH-1:1]};
    mul_take = s1_v_q && (s1_f_q == F_MUL);
  end
`endif

  always_comb begin
`ifdef ALU_MUL_EN
    s1_adv = (mul_st_q != MUL_BUSY) && (!s2_v_q || bus.out_ready);
`else
    s1_adv = !s2_v_q || bus.out_ready;
`endif
    in_rdy  = !s1_v_q || s1_adv;

    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_sh_d = s1_sh_q;
    s1_f_d  = s1_f_q;
    s2_v_d  = s2_v_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    mul_st_d    = mul_st_q;
    mul_cnt_d   = mul_cnt_q;
    mul_mcand_d = mul_mcand_q;
    mul_prod_d  = mul_prod_q;
`endif

    if (in_rdy) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d  = bus.a;
        s1_b_d  = bus.b;
        s1_sh_d = bus.shamt;
        s1_f_d  = bus.funct;
      end
    end

    if (s1_adv) begin
      s2_v_d = s1_v_q;
`ifdef ALU_MUL_EN
      mul_st_d = MUL_IDLE;
      if (mul_take) begin
        // Result stays invisible until the iteration finishes.
        s2_v_d      = 1'b0;
        mul_st_d    = MUL_BUSY;
        mul_cnt_d   = '0;
        mul_mcand_d = s1_a_q;
        mul_prod_d  = {{WIDTH{1'b0}}, s1_b_q};
      end else if (s1_v_q) begin
        res_d   = alu_res;
        flags_d = alu_flags;
        err_d   = alu_illegal;
      end
`else
      if (s1_v_q) begin
        res_d   = alu_res;
        flags_d = alu_flags;
        err_d   = alu_illegal;
      end
`endif
    end

`ifdef ALU_MUL_EN
    if (mul_st_q == MUL_BUSY) begin
      mul_prod_d = mul_step;
      mul_cnt_d  = mul_cnt_q + 1'b1;
      if (mul_cnt_q == SHW'(WIDTH - 1)) begin
        mul_st_d = MUL_DONE;
        s2_v_d   = 1'b1;
        res_d    = mul_step[WIDTH-1:0];
        flags_d  = {1'b0, (mul_step[2*WIDTH-1:WIDTH] != '0),
                    mul_step[WIDTH-1], (mul_step[WIDTH-1:0] == '0)};
        err_d    = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_sh_q <= '0;
      s1_f_q  <= '0;
      s2_v_q  <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mul_st_q    <= MUL_IDLE;
      mul_cnt_q   <= '0;
      mul_mcand_q <= '0;
      mul_prod_q  <= '0;
`endif
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_sh_q <= s1_sh_d;
      s1_f_q  <= s1_f_d;
      s2_v_q  <= s2_v_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      mul_st_q    <= mul_st_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_mcand_q <= mul_mcand_d;
      mul_prod_q  <= mul_prod_d;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_v_q;
  assign bus.res       = res_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule
